// File: rtl/poly_music_player_pkg.sv
// Shared state encoding, default parameters and saturation limits for poly_music_player.
package poly_music_player_pkg;

    localparam int unsigned DEF_NUM_SONGS   = 4;
    localparam int unsigned DEF_NUM_VOICES  = 3;
    localparam int unsigned DEF_SAMPLE_W    = 16;
    localparam int unsigned DEF_BEAT_DIV    = 1000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
    localparam int unsigned ATTEN_W = 3;
`endif

    typedef enum logic [1:0] {
        ST_RESTART = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_PLAYING = 2'd2,
        ST_ADVANCE = 2'd3
    } state_e;

    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/poly_music_player_voice_mixer.sv
// Combinational N-voice signed sum with saturation to SAMPLE_W bits.
// With POLY_MUSIC_PLAYER_VOLUME_EN the saturated mix is arithmetic-shifted by atten.
module poly_music_player_voice_mixer
    import poly_music_player_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W
) (
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_valid,
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
    input  logic [ATTEN_W-1:0]             atten,
`endif
    output logic [SAMPLE_W-1:0]            mix_c
);

    // Three guard bits hold the sum of up to eight full-scale voices.
    localparam int unsigned SUM_W = SAMPLE_W + 3;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sat_max(SAMPLE_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sat_min(SAMPLE_W));

    logic signed [SUM_W-1:0]    sum_c;
    logic signed [SAMPLE_W-1:0] sat_c;

    always_comb begin
        logic signed [SAMPLE_W-1:0] v;
        v     = '0;
        sum_c = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            v = $signed(voice_sample[i*SAMPLE_W +: SAMPLE_W]);
            if (voice_valid[i]) begin
                sum_c = sum_c + SUM_W'(v);
            end
        end
    end

    always_comb begin
        if (sum_c > SUM_MAX) begin
            sat_c = SAMPLE_W'(SUM_MAX);
        end else if (sum_c < SUM_MIN) begin
            sat_c = SAMPLE_W'(SUM_MIN);
        end else begin
            sat_c = SAMPLE_W'(sum_c);
        end
    end

`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
    assign mix_c = sat_c >>> atten;
`else
    assign mix_c = sat_c;
`endif

endmodule

// File: rtl/poly_music_player.sv
// Music player top: song FSM, new_frame synchroniser, beat counter and registered voice mix.
// Optional POLY_MUSIC_PLAYER_VOLUME_EN adds vol_up/vol_down and a 3-bit attenuation.
module poly_music_player
    import poly_music_player_pkg::*;
#(
    parameter int unsigned NUM_SONGS   = DEF_NUM_SONGS,
    parameter int unsigned NUM_VOICES  = DEF_NUM_VOICES,
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned BEAT_DIV    = DEF_BEAT_DIV,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int unsigned SONG_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_pause,
    input  logic                           next,
    input  logic                           prev,
    input  logic                           song_done,
    input  logic                           new_frame,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_valid,
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
    input  logic                           vol_up,
    input  logic                           vol_down,
`endif
    output logic                           play,
    output logic                           reset_play,
    output logic [SONG_W-1:0]              song,
    output logic                           sampling_pulse,
    output logic                           beat,
    output logic [SAMPLE_W-1:0]            sample,
    output logic                           sample_ready
);

    localparam int unsigned CNT_W = $clog2(BEAT_DIV);

    state_e                  state_q, state_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic                    resume_q, resume_d;
    logic                    play_q, play_d;
    logic                    reset_play_q, reset_play_d;
    logic [SYNC_STAGES:0]    sync_q, sync_d;
    logic                    pulse_q, pulse_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    beat_q, beat_d;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic                    ready_q, ready_d;
    logic [SAMPLE_W-1:0]     mix_c;
    logic                    song_last_c;
    logic [SONG_W-1:0]       song_inc_c, song_dec_c;

`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
    logic [ATTEN_W-1:0]      atten_q, atten_d;

    // vol_up lowers attenuation, vol_down raises it; simultaneous presses cancel.
    always_comb begin
        atten_d = atten_q;
        if (vol_up && !vol_down && atten_q != '0) begin
            atten_d = atten_q - ATTEN_W'(1);
        end else if (vol_down && !vol_up && atten_q != '1) begin
            atten_d = atten_q + ATTEN_W'(1);
        end
    end
`endif

    assign song_last_c = (song_q == SONG_W'(NUM_SONGS - 1));
    assign song_inc_c  = song_last_c ? '0 : song_q + SONG_W'(1);
    assign song_dec_c  = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - SONG_W'(1);

    // Song FSM: next > prev > song_done > play_pause; RESTART decides resume vs pause.
    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        resume_d = resume_q;
        case (state_q)
            ST_RESTART: state_d = resume_q ? ST_PLAYING : ST_PAUSED;
            ST_ADVANCE: begin
                song_d   = song_inc_c;
                resume_d = !song_last_c;
                state_d  = ST_RESTART;
            end
            default: begin
                if (next) begin
                    song_d   = song_inc_c;
                    resume_d = (state_q == ST_PLAYING);
                    state_d  = ST_RESTART;
                end else if (prev) begin
                    song_d   = song_dec_c;
                    resume_d = (state_q == ST_PLAYING);
                    state_d  = ST_RESTART;
                end else if (song_done && state_q == ST_PLAYING) begin
                    state_d = ST_ADVANCE;
                end else if (play_pause) begin
                    state_d = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
                end
            end
        endcase
        play_d       = (state_d == ST_PLAYING);
        reset_play_d = (state_d == ST_RESTART);
    end

    // Top sync bit is the delayed copy used for rising-edge detection.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-1:0], new_frame};
        pulse_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    end

    always_comb begin
        cnt_d  = cnt_q;
        beat_d = 1'b0;
        if (reset_play_q) begin
            cnt_d = '0;
        end else if (play_q && pulse_q) begin
            if (cnt_q == CNT_W'(BEAT_DIV - 1)) begin
                cnt_d  = '0;
                beat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        sample_d = sample_q;
        ready_d  = pulse_q;
        if (pulse_q) begin
            sample_d = play_q ? mix_c : '0;
        end
    end

    poly_music_player_voice_mixer #(
        .NUM_VOICES (NUM_VOICES),
        .SAMPLE_W   (SAMPLE_W)
    ) u_voice_mixer (
        .voice_sample (voice_sample),
        .voice_valid  (voice_valid),
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
        .atten        (atten_q),
`endif
        .mix_c        (mix_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RESTART;
            song_q       <= '0;
            resume_q     <= 1'b0;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
            sync_q       <= '0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
            beat_q       <= 1'b0;
            sample_q     <= '0;
            ready_q      <= 1'b0;
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
            atten_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            resume_q     <= resume_d;
            play_q       <= play_d;
            reset_play_q <= reset_play_d;
            sync_q       <= sync_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            sample_q     <= sample_d;
            ready_q      <= ready_d;
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
            atten_q      <= atten_d;
`endif
        end
    end

    assign play           = play_q;
    assign reset_play     = reset_play_q;
    assign song           = song_q;
    assign sampling_pulse = pulse_q;
    assign beat           = beat_q;
    assign sample         = sample_q;
    assign sample_ready   = ready_q;

endmodule

// File: tb/tb_poly_music_player.sv
// Bench for poly_music_player: directed scenarios plus random stimulus against a behavioural model.
module tb_poly_music_player;

    localparam int NUM_SONGS   = 4;
    localparam int NUM_VOICES  = 3;
    localparam int SAMPLE_W    = 16;
    localparam int BEAT_DIV    = 64;
    localparam int SYNC_STAGES = 2;

    typedef enum int {M_RESTART, M_PAUSED, M_PLAYING, M_ADVANCE} mode_e;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_pause = 1'b0, next = 1'b0, prev = 1'b0, song_done = 1'b0;
    logic        new_frame = 1'b0;
    logic [47:0] voice_sample = '0;
    logic [2:0]  voice_valid = '0;
    logic        play, reset_play, sampling_pulse, beat, sample_ready;
    logic [1:0]  song;
    logic [15:0] sample;

    always #5 clk = ~clk;

    poly_music_player #(
        .NUM_SONGS   (NUM_SONGS),
        .NUM_VOICES  (NUM_VOICES),
        .SAMPLE_W    (SAMPLE_W),
        .BEAT_DIV    (BEAT_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .play_pause     (play_pause),
        .next           (next),
        .prev           (prev),
        .song_done      (song_done),
        .new_frame      (new_frame),
        .voice_sample   (voice_sample),
        .voice_valid    (voice_valid),
`ifdef POLY_MUSIC_PLAYER_VOLUME_EN
        .vol_up         (1'b0),
        .vol_down       (1'b0),
`endif
        .play           (play),
        .reset_play     (reset_play),
        .song           (song),
        .sampling_pulse (sampling_pulse),
        .beat           (beat),
        .sample         (sample),
        .sample_ready   (sample_ready)
    );

    int n_vec = 0;
    int n_err = 0;
    int beat_seen = 0;
    int pulse_seen = 0;

    // Stimulus levels held across steps.
    bit          nf_lvl = 1'b0;
    logic [47:0] vs_lvl = '0;
    logic [2:0]  vv_lvl = '0;

    // Reference model state.
    mode_e       m_mode;
    int          m_song;
    bit          m_resume;
    int          m_cnt;
    bit          m_beat;
    logic [15:0] m_sample;
    bit          m_ready;
    bit          m_pulse;
    bit          nf_hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode   = M_RESTART;
        m_song   = 0;
        m_resume = 1'b0;
        m_cnt    = 0;
        m_beat   = 1'b0;
        m_sample = '0;
        m_ready  = 1'b0;
        m_pulse  = 1'b0;
        nf_hist.delete();
    endfunction

    // One clock of the player, evaluated from the current model outputs and the applied inputs.
    function automatic void model_step(bit pp, bit nx, bit pv, bit sd, bit nf,
                                       logic [47:0] vs, logic [2:0] vv);
        bit play_c  = (m_mode == M_PLAYING);
        bit rp_c    = (m_mode == M_RESTART);
        bit pulse_c = m_pulse;
        int sum;
        int n;
        logic signed [15:0] s;

        if (rp_c) begin
            m_cnt  = 0;
            m_beat = 1'b0;
        end else if (play_c && pulse_c) begin
            m_beat = (m_cnt == BEAT_DIV - 1);
            m_cnt  = (m_cnt + 1) % BEAT_DIV;
        end else begin
            m_beat = 1'b0;
        end

        m_ready = pulse_c;
        if (pulse_c) begin
            sum = 0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                s = vs[v*16 +: 16];
                if (vv[v]) sum += int'(s);
            end
            if (sum > 32767) sum = 32767;
            if (sum < -32768) sum = -32768;
            if (!play_c) sum = 0;
            m_sample = 16'(sum);
        end

        nf_hist.push_back(nf);
        if (nf_hist.size() > SYNC_STAGES + 2) void'(nf_hist.pop_front());
        n = nf_hist.size();
        m_pulse = 1'b0;
        if (n >= SYNC_STAGES + 1) begin
            m_pulse = nf_hist[n-1-SYNC_STAGES] && ((n < SYNC_STAGES + 2) || !nf_hist[n-2-SYNC_STAGES]);
        end

        case (m_mode)
            M_RESTART: m_mode = m_resume ? M_PLAYING : M_PAUSED;
            M_ADVANCE: begin
                if (m_song == NUM_SONGS - 1) begin
                    m_song   = 0;
                    m_resume = 1'b0;
                end else begin
                    m_song   = m_song + 1;
                    m_resume = 1'b1;
                end
                m_mode = M_RESTART;
            end
            default: begin
                if (nx) begin
                    m_song   = (m_song + 1) % NUM_SONGS;
                    m_resume = (m_mode == M_PLAYING);
                    m_mode   = M_RESTART;
                end else if (pv) begin
                    m_song   = (m_song + NUM_SONGS - 1) % NUM_SONGS;
                    m_resume = (m_mode == M_PLAYING);
                    m_mode   = M_RESTART;
                end else if (sd && m_mode == M_PLAYING) begin
                    m_mode = M_ADVANCE;
                end else if (pp) begin
                    m_mode = (m_mode == M_PLAYING) ? M_PAUSED : M_PLAYING;
                end
            end
        endcase
    endfunction

    task automatic check_all();
        check_eq("play",           32'(play),           32'(m_mode == M_PLAYING));
        check_eq("reset_play",     32'(reset_play),     32'(m_mode == M_RESTART));
        check_eq("song",           32'(song),           32'(m_song));
        check_eq("sampling_pulse", 32'(sampling_pulse), 32'(m_pulse));
        check_eq("beat",           32'(beat),           32'(m_beat));
        check_eq("sample",         32'(sample),         32'(m_sample));
        check_eq("sample_ready",   32'(sample_ready),   32'(m_ready));
        if (beat === 1'b1) beat_seen++;
        if (sampling_pulse === 1'b1) pulse_seen++;
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle.
    task automatic step(input bit pp, input bit nx, input bit pv, input bit sd);
        check_all();
        play_pause   = pp;
        next         = nx;
        prev         = pv;
        song_done    = sd;
        new_frame    = nf_lvl;
        voice_sample = vs_lvl;
        voice_valid  = vv_lvl;
        model_step(pp, nx, pv, sd, nf_lvl, vs_lvl, vv_lvl);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            nf_lvl = 1'b1;
            idle(2);
            nf_lvl = 1'b0;
            idle(2);
        end
    endtask

    // Raise new_frame once, check pulse latency, then the registered sample.
    task automatic frame_check(input string tag, input logic [15:0] exp_s);
        int n = 0;
        nf_lvl = 1'b1;
        while (sampling_pulse !== 1'b1 && n < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(SYNC_STAGES + 1));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq({tag, "_ready"}, 32'(sample_ready), 32'd1);
        check_eq(tag, 32'(sample), 32'(exp_s));
        nf_lvl = 1'b0;
        idle(3);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_song",       32'(song),           32'd0);
        check_eq("rst_play",       32'(play),           32'd0);
        check_eq("rst_reset_play", 32'(reset_play),     32'd1);
        check_eq("rst_sample",     32'(sample),         32'd0);
        check_eq("rst_ready",      32'(sample_ready),   32'd0);
        check_eq("rst_beat",       32'(beat),           32'd0);
        check_eq("rst_pulse",      32'(sampling_pulse), 32'd0);
        model_reset();
        play_pause = 1'b0;
        next       = 1'b0;
        prev       = 1'b0;
        song_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] pick_sample();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset release then play_pause.
        check_eq("t1_reset_play", 32'(reset_play), 32'd1);
        idle(1);
        check_eq("t1_paused_play", 32'(play), 32'd0);
        check_eq("t1_paused_rp",   32'(reset_play), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t1_play", 32'(play), 32'd1);
        check_eq("t1_song", 32'(song), 32'd0);

        // Beat generation and pause hold.
        beat_seen  = 0;
        pulse_seen = 0;
        frames(128);
        idle(8);
        check_eq("t2_beats_128",  32'(beat_seen), 32'd2);
        check_eq("t2_pulses_128", 32'(pulse_seen), 32'd128);
        frames(32);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        frames(5);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        beat_seen = 0;
        frames(31);
        idle(6);
        check_eq("t2_beats_63", 32'(beat_seen), 32'd0);
        frames(1);
        idle(6);
        check_eq("t2_beats_64", 32'(beat_seen), 32'd1);

        // next wraps 3 -> 0 while playing, prev wraps 0 -> 3.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        check_eq("t3_song3", 32'(song), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_next_song", 32'(song), 32'd0);
        check_eq("t3_next_rp",   32'(reset_play), 32'd1);
        idle(1);
        check_eq("t3_next_play", 32'(play), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t3_prev_song", 32'(song), 32'd3);
        idle(1);
        check_eq("t3_prev_play", 32'(play), 32'd1);

        // song_done auto-advance: wrap ends paused, non-wrap keeps playing.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_adv_play", 32'(play), 32'd0);
        check_eq("t4_adv_rp",   32'(reset_play), 32'd0);
        idle(1);
        check_eq("t4_wrap_song", 32'(song), 32'd0);
        check_eq("t4_wrap_rp",   32'(reset_play), 32'd1);
        idle(1);
        check_eq("t4_wrap_paused", 32'(play), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check_eq("t4_paused_next_song", 32'(song), 32'd1);
        check_eq("t4_paused_next_play", 32'(play), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_eq("t4_adv_song2", 32'(song), 32'd2);
        check_eq("t4_adv_play2", 32'(play), 32'd1);

        // next beats play_pause in the same cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_song", 32'(song), 32'd3);
        check_eq("t6_rp",   32'(reset_play), 32'd1);
        idle(1);
        check_eq("t6_play", 32'(play), 32'd1);

        // Mixer saturation and voice masking.
        vs_lvl = {3{16'h7000}};
        vv_lvl = 3'b111;
        idle(2);
        frame_check("t5_sat_hi", 16'h7FFF);
        vs_lvl = {3{16'h9000}};
        frame_check("t5_sat_lo", 16'h8000);
        vs_lvl = {16'h7FFF, 16'h7FFF, 16'h1234};
        vv_lvl = 3'b001;
        frame_check("t5_single", 16'h1234);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        frame_check("t5_paused_zero", 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional mid-run resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) nf_lvl = ~nf_lvl;
            if ($urandom_range(0, 7) == 0) begin
                vv_lvl = 3'($urandom);
                for (int v = 0; v < NUM_VOICES; v++) vs_lvl[v*16 +: 16] = pick_sample();
            end
            step($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
            if (c == 1000 || c == 2200) do_reset();
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/poly_music_player.md
Name: poly_music_player

Overview:
- Parametrised successor top-level controller for the music player.
- Owns song selection FSM (play/pause, next, prev, auto-advance), frame-pulse synchronisation, beat generation, and an N-voice saturating sample mixer.
- Sits between button debouncers, song readers / note players (one per voice) and the codec interface.
- Generalises the single-voice player to NUM_VOICES voices, NUM_SONGS songs and a configurable beat divider.

Parameters:
- NUM_SONGS, 4, number of selectable songs; SONG_W = max(1, clog2(NUM_SONGS)) derived.
- NUM_VOICES, 3, voices mixed per sample (1..8).
- SAMPLE_W, 16, signed sample width per voice and at output.
- BEAT_DIV, 1000, sampling pulses per beat (>=2); simulation builds use 64.
- SYNC_STAGES, 2, flops in the new_frame synchroniser (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_pause  in  1  one-cycle debounced pulse, toggles play
- next  in  1  one-cycle pulse, advance song
- prev  in  1  one-cycle pulse, previous song
- song_done  in  1  level/pulse from song reader, current song finished
- new_frame  in  1  asynchronous codec frame strobe (level)
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed signed samples, voice 0 in LSBs
- voice_valid  in  NUM_VOICES  per-voice enable; invalid voice contributes 0
- play  out  1  high while playing
- reset_play  out  1  one-cycle clear to song readers / note players
- song  out  SONG_W  current song index
- sampling_pulse  out  1  one-cycle pulse per codec frame
- beat  out  1  one-cycle pulse every BEAT_DIV sampling pulses
- sample  out  SAMPLE_W  mixed signed output sample
- sample_ready  out  1  one-cycle pulse, sample updated

Behaviour:
- Reset (reset=0): state RESTART, song=0, play=0, reset_play=1, beat=0, sampling_pulse=0, sample=0, sample_ready=0, all counters and sync flops 0.
- FSM states: RESTART, PAUSED, PLAYING, ADVANCE.
  - RESTART: reset_play=1 for exactly one cycle. Goes to PLAYING if the resume flag is set, else PAUSED. The resume flag is cleared on reset.
  - PAUSED: play_pause goes to PLAYING. next/prev update song, set resume=0, go to RESTART.
  - PLAYING: play_pause goes to PAUSED; song position is kept, no reset_play. next/prev update song, set resume=1, go to RESTART. song_done goes to ADVANCE.
  - ADVANCE: one cycle; song increments.
    - Not wrapping: resume=1, go to RESTART.
    - Wrapping NUM_SONGS-1 to 0: resume=0, go to RESTART, which ends in PAUSED.
- Event priority in the same cycle: next > prev > song_done > play_pause. Lower-priority events that cycle are dropped.
- Song index wraps: next at NUM_SONGS-1 gives 0; prev at 0 gives NUM_SONGS-1.
- play=1 only in PLAYING.
- Synchroniser:
  - new_frame passes through SYNC_STAGES flops, then a rising-edge detector.
  - sampling_pulse asserts SYNC_STAGES+1 cycles after the new_frame rise; one pulse per rise.
  - Runs in every state.
- Beat counter:
  - Counts sampling_pulse only while play=1; holds while paused; cleared by reset_play.
  - beat=1 in the cycle the counter wraps BEAT_DIV-1 to 0, registered.
- Mixer:
  - On sampling_pulse, sums the valid voices sign-extended to SAMPLE_W+3 bits.
  - Saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Registers sample and pulses sample_ready one cycle after sampling_pulse.
  - When play=0, the captured sum is forced to 0; sample_ready still pulses.
- Reset mid-operation: all state returns to reset values immediately (async).

Optional Feature:
- Macro: POLY_MUSIC_PLAYER_VOLUME_EN.
- With the macro: adds inputs vol_up and vol_down (one-cycle pulses) and a 3-bit attenuation register, reset value 0.
  - vol_up decrements the register, saturating at 0; vol_down increments it, saturating at 7.
  - Both pulses in the same cycle: no change.
  - The saturated mix is arithmetic-right-shifted by the attenuation before registering; latency is unchanged.
- Without the macro: no ports, no register; output is the unshifted saturated mix.

Decomposition:
- Package poly_music_player_pkg: FSM state enum, default widths, SAT_MAX/SAT_MIN constants as functions of SAMPLE_W.
- One natural sub-module: voice_mixer (combinational sum and saturation, with the optional shift).
- FSM, synchroniser and beat counter stay in the top.

Test Plan:
1. Reset release, then play_pause: one reset_play cycle after reset, PAUSED; play_pause gives play=1 next cycle, song=0.
2. BEAT_DIV=64, 128 new_frame rises while playing: exactly 2 beat pulses; pause after 32 frames, resume, and the 64th counted frame still produces beat.
3. next at song=3 (NUM_SONGS=4) while PLAYING: song=0, one reset_play pulse, returns to PLAYING; prev at song=0 gives song=3.
4. song_done on song 3: ADVANCE, song=0, reset_play, ends PAUSED; song_done on song 1 gives song=2 and stays PLAYING.
5. Saturation, 3 voices of 0x7000 valid: sample=0x7FFF. Three voices of 0x9000: sample=0x8000. voice_valid=3'b001 with 0x1234: sample=0x1234, sample_ready one cycle after sampling_pulse.
6. Simultaneous next+play_pause in PLAYING: next wins, song increments, play remains 1 after RESTART.
